knn_sorted_list: RTL and testbench
==================================

# knn_sorted_list

Parametrised K-entry nearest-neighbour list for the KNN accelerator. Keeps the K smallest unsigned distances seen since the last `start`, each with its label, sorted in ascending order. It extends the single-entry compare-and-load list element to a full insertion-sorted shift list with occupancy tracking, a run/done state machine and a hit indication. It sits after the distance unit and feeds the label-voting stage through a flat list bus.

## Interface
Parameters:
- `DATA_W`, 32, distance width (unsigned)
- `LABEL_W`, 8, label width
- `K`, 4, list depth (number of neighbours kept), K >= 1

Ports (clock is `clk`; reset is `rst`, synchronous, active-high):
- `clk`  in  1  clock, all state updates on the rising edge
- `rst`  in  1  synchronous active-high reset
- `start`  in  1  clear list and enter RUN
- `valid`  in  1  candidate present this cycle
- `last`  in  1  qualifies `valid`: this is the final candidate of the query
- `dist_in`  in  DATA_W  candidate distance
- `label_in`  in  LABEL_W  candidate label
- `list_out`  out  K*(DATA_W+LABEL_W)  entry i at bits [(i+1)*(DATA_W+LABEL_W)-1 : i*(DATA_W+LABEL_W)], formatted {dist, label}; entry 0 is the nearest
- `occ`  out  K  bit i = entry i holds a valid neighbour
- `count`  out  $clog2(K+1)  number of occupied entries, 0..K
- `hit`  out  1  registered pulse: the previous cycle's candidate was inserted
- `done`  out  1  list final for this query (DONE state)

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: after reset. `valid` is ignored.
  - RUN: candidates are accepted.
  - DONE: the list is frozen and `valid` is ignored.
- Transitions:
  - `start` in any state: go to RUN and clear all of `occ`.
  - RUN with `valid & last`: go to DONE.
  - `last` without `valid` has no effect.
- Accepted candidate: `valid` high in RUN, or `valid` high in the same cycle as `start` from any state.
- Comparison per entry i: `lt[i] = !occ[i] | (dist_in < dist[i])`, strict unsigned. `lt` is monotonic over i because the list is sorted and occupancy is packed from entry 0.
- Update on an accepted candidate, per entry i:
  - if `lt[i]` and (i==0 or !`lt[i-1]`): load the candidate and set `occ[i]`.
  - else if i>0 and `lt[i-1]`: load entry i-1, including its occ bit.
  - otherwise hold.
  - Entry K-1 is discarded on a shift.
- Ties: a candidate equal to a stored distance is placed after it, so the earlier arrival ranks nearer.
- Candidate not inserted (no `lt` bit set, i.e. the list is full and `dist_in` >= entry K-1): list unchanged, `hit` stays 0.
- `start` together with `valid`: clear first, then insert, so the result is a list holding only the candidate at entry 0, `count`=1. If `last` is also high, the next state is DONE.
- `count` increments on every insertion while below K and saturates at K. It is cleared by `start`, then set to 1 if a candidate is inserted that same cycle.
- Label and distance bits of unoccupied entries are don't-care for consumers. The implementation clears them to 0 on `rst` and `start`.

## Timing
- Reset values: `list_out`=0, `occ`=0, `count`=0, `hit`=0, `done`=0, state IDLE.
- `rst` overrides `start` and `valid` in the same cycle.
- `rst` mid-query discards the list; `start` is required before new inserts are accepted.
- Latency:
  - candidate at edge n, visible on `list_out`/`occ`/`count` after edge n+1;
  - `hit` high for exactly the cycle following an insertion.
- Throughput: one candidate per cycle, back-to-back. No ready signal; the block never stalls.
- `done`: high from the cycle after the `valid & last` acceptance until the cycle after the next `start` or `rst`.
- `list_out` is stable in DONE and IDLE.
- Single-cycle compare-shift. The critical path is one DATA_W comparator plus a 3:1 mux per entry.

## Test plan
All cases use K=4, DATA_W=8, LABEL_W=4.
- Reset then `valid` in IDLE with dist 5 -> `occ`=0000, `count`=0, `hit`=0.
- `start`; then dists 9,3,7,1 (labels 1,2,3,4) back-to-back -> after 4 cycles entries = (1,L4),(3,L2),(7,L3),(9,L1), `count`=4, `hit` high 4 consecutive cycles.
- Continue: dist 8 -> (1,3,7,8) with 9 dropped, `hit`=1; then dist 20 -> list unchanged, `hit`=0, `count` stays 4.
- Tie: list (1,3,7,8), insert dist 3 label 9 -> (1,L4),(3,L2),(3,L9),(7,L3).
- `valid & last` dist 2 -> inserted at entry 1, `done`=1 next cycle; a following `valid` dist 0 is ignored. Then `start & valid` dist 6 -> `occ`=0001, entry0=(6), `count`=1, `done`=0.
- `rst` asserted together with `start & valid` mid-RUN -> all outputs at reset values the next cycle, state IDLE.

Source files
------------

// File: rtl/knn_sorted_list.sv
// knn_sorted_list: K-entry insertion-sorted nearest-neighbour list.
// Holds the K smallest unsigned distances (with labels) since the last start,
// ascending from entry 0. One candidate per cycle, single-cycle compare-shift.
module knn_sorted_list #(
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 8,
  parameter int K       = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             valid,
  input  logic                             last,
  input  logic [DATA_W-1:0]                dist_in,
  input  logic [LABEL_W-1:0]               label_in,
  output logic [K*(DATA_W+LABEL_W)-1:0]    list_out,
  output logic [K-1:0]                     occ,
  output logic [$clog2(K+1)-1:0]           count,
  output logic                             hit,
  output logic                             done
);

  localparam int          EW    = DATA_W + LABEL_W;
  localparam int          CW    = $clog2(K + 1);
  localparam int unsigned KU    = K;
  localparam logic [CW-1:0] K_CNT = CW'(K);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [DATA_W-1:0]  dist_q     [K];
  logic [LABEL_W-1:0] label_q    [K];
  logic [DATA_W-1:0]  dist_base  [K];
  logic [LABEL_W-1:0] label_base [K];
  logic [DATA_W-1:0]  dist_next  [K];
  logic [LABEL_W-1:0] label_next [K];
  logic [K-1:0]       occ_base, occ_next, lt;
  logic [CW-1:0]      count_base, count_next;
  logic               accept, insert;

  // Start clears the list before the compare, so a candidate arriving with
  // start is compared against an empty list and lands in entry 0.
  always_comb begin
    occ_base   = start ? '0 : occ;
    count_base = start ? '0 : count;
    for (int unsigned i = 0; i < KU; i++) begin
      dist_base[i]  = start ? '0 : dist_q[i];
      label_base[i] = start ? '0 : label_q[i];
      lt[i]         = !occ_base[i] | (dist_in < dist_base[i]);
    end
  end

  assign accept = valid & (start | (state == RUN));
  assign insert = accept & (|lt);

  // Per-entry 3:1 select: load candidate, shift from entry i-1, or hold.
  always_comb begin
    occ_next = occ_base;
    for (int unsigned i = 0; i < KU; i++) begin
      dist_next[i]  = dist_base[i];
      label_next[i] = label_base[i];
    end
    if (accept) begin
      if (lt[0]) begin
        dist_next[0]  = dist_in;
        label_next[0] = label_in;
        occ_next[0]   = 1'b1;
      end
      for (int unsigned i = 1; i < KU; i++) begin
        if (lt[i] && !lt[i-1]) begin
          dist_next[i]  = dist_in;
          label_next[i] = label_in;
          occ_next[i]   = 1'b1;
        end else if (lt[i-1]) begin
          dist_next[i]  = dist_base[i-1];
          label_next[i] = label_base[i-1];
          occ_next[i]   = occ_base[i-1];
        end
      end
    end
  end

  // Occupancy count, saturating at K.
  always_comb begin
    count_next = count_base;
    if (insert && (count_base < K_CNT)) count_next = count_base + CW'(1);
  end

  // Next-state logic for the IDLE/RUN/DONE query sequencer.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = (valid && last) ? DONE : RUN;
    end else if ((state == RUN) && valid && last) begin
      state_next = DONE;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // List storage, occupancy, count and insertion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < KU; i++) begin
        dist_q[i]  <= '0;
        label_q[i] <= '0;
      end
      occ   <= '0;
      count <= '0;
      hit   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < KU; i++) begin
        dist_q[i]  <= dist_next[i];
        label_q[i] <= label_next[i];
      end
      occ   <= occ_next;
      count <= count_next;
      hit   <= insert;
    end
  end

  // Flatten entries onto the list bus as {dist, label}, entry 0 lowest.
  always_comb begin
    list_out = '0;
    for (int unsigned i = 0; i < KU; i++) begin
      list_out[i*EW +: EW] = {dist_q[i], label_q[i]};
    end
  end

  assign done = (state == DONE);

endmodule

// File: tb/tb_knn_sorted_list.sv
// Testbench for knn_sorted_list (K=4, DATA_W=8, LABEL_W=4): directed vector
// table plus randomized traffic against a queue-based reference model.
module tb_knn_sorted_list;

  localparam int K = 4;
  localparam int DW = 8;
  localparam int LW = 4;
  localparam int EW = DW + LW;

  logic              clk = 1'b0;
  logic              rst, start, valid, last;
  logic [DW-1:0]     dist_in;
  logic [LW-1:0]     label_in;
  logic [K*EW-1:0]   list_out;
  logic [K-1:0]      occ;
  logic [2:0]        count;
  logic              hit, done;

  knn_sorted_list #(.DATA_W(DW), .LABEL_W(LW), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .valid(valid), .last(last),
    .dist_in(dist_in), .label_in(label_in), .list_out(list_out),
    .occ(occ), .count(count), .hit(hit), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: ordered queue of neighbours plus phase flags.
  typedef struct { logic [DW-1:0] d; logic [LW-1:0] l; } ent_t;
  ent_t m_q[$];
  int   m_phase;     // 0 idle, 1 collecting, 2 finished
  bit   m_hit;

  typedef struct {
    bit rst, start, valid, last;
    int d, l;
    logic [K*EW-1:0] e_list;
    int e_occ, e_count;
    bit e_hit, e_done;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [K*EW-1:0] pk(input int d0, l0, d1, l1, d2, l2, d3, l3);
    return {8'(d3), 4'(l3), 8'(d2), 4'(l2), 8'(d1), 4'(l1), 8'(d0), 4'(l0)};
  endfunction

  task automatic add(input bit r, s, v, la, input int d, l,
                     input logic [K*EW-1:0] el, input int eo, ec, input bit eh, ed);
    vec_t x;
    x.rst = r; x.start = s; x.valid = v; x.last = la; x.d = d; x.l = l;
    x.e_list = el; x.e_occ = eo; x.e_count = ec; x.e_hit = eh; x.e_done = ed;
    vecs.push_back(x);
  endtask

  function automatic void model_step(input bit r, s, v, la, input int d, l);
    bit acc;
    int pos;
    ent_t e;
    if (r) begin
      m_q.delete(); m_phase = 0; m_hit = 0;
      return;
    end
    acc = v && (s || m_phase == 1);
    if (s) m_q.delete();
    m_hit = 0;
    if (acc) begin
      pos = m_q.size();
      for (int j = 0; j < m_q.size(); j++)
        if (d < int'(m_q[j].d)) begin pos = j; break; end
      if (pos < K) begin
        e.d = DW'(d); e.l = LW'(l);
        m_q.insert(pos, e);
        if (m_q.size() > K) void'(m_q.pop_back());
        m_hit = 1;
      end
    end
    if (s) m_phase = (v && la) ? 2 : 1;
    else if (m_phase == 1 && v && la) m_phase = 2;
  endfunction

  // Drive one cycle from a negedge, advance the model at the posedge and
  // compare every output at the following negedge.
  task automatic cycle(input string tag, input bit r, s, v, la, input int d, l);
    logic [K*EW-1:0] el;
    rst = r; start = s; valid = v; last = la;
    dist_in = DW'(d); label_in = LW'(l);
    @(posedge clk);
    model_step(r, s, v, la, d, l);
    @(negedge clk);
    el = '0;
    for (int j = 0; j < m_q.size(); j++) el[j*EW +: EW] = {m_q[j].d, m_q[j].l};
    check({tag, "_m_list"},  64'(list_out), 64'(el));
    check({tag, "_m_occ"},   64'(occ),      64'((1 << m_q.size()) - 1));
    check({tag, "_m_count"}, 64'(count),    64'(m_q.size()));
    check({tag, "_m_hit"},   64'(hit),      64'(m_hit));
    check({tag, "_m_done"},  64'(done),     64'(m_phase == 2));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; last = 1'b0;
    dist_in = '0; label_in = '0;
    m_phase = 0; m_hit = 0;

    //   rst s v l  dist lab  expected list                          occ  cnt hit done
    add(1, 0, 0, 0, 0,  0,  pk(0,0, 0,0, 0,0, 0,0),              4'h0, 0, 0, 0);
    add(0, 0, 1, 0, 5,  1,  pk(0,0, 0,0, 0,0, 0,0),              4'h0, 0, 0, 0);
    add(0, 1, 0, 0, 0,  0,  pk(0,0, 0,0, 0,0, 0,0),              4'h0, 0, 0, 0);
    add(0, 0, 1, 0, 9,  1,  pk(9,1, 0,0, 0,0, 0,0),              4'h1, 1, 1, 0);
    add(0, 0, 1, 0, 3,  2,  pk(3,2, 9,1, 0,0, 0,0),              4'h3, 2, 1, 0);
    add(0, 0, 1, 0, 7,  3,  pk(3,2, 7,3, 9,1, 0,0),              4'h7, 3, 1, 0);
    add(0, 0, 1, 0, 1,  4,  pk(1,4, 3,2, 7,3, 9,1),              4'hF, 4, 1, 0);
    add(0, 0, 1, 0, 8,  5,  pk(1,4, 3,2, 7,3, 8,5),              4'hF, 4, 1, 0);
    add(0, 0, 1, 0, 20, 6,  pk(1,4, 3,2, 7,3, 8,5),              4'hF, 4, 0, 0);
    add(0, 0, 1, 0, 3,  9,  pk(1,4, 3,2, 3,9, 7,3),              4'hF, 4, 1, 0);
    add(0, 0, 1, 1, 2,  7,  pk(1,4, 2,7, 3,2, 3,9),              4'hF, 4, 1, 1);
    add(0, 0, 1, 0, 0,  8,  pk(1,4, 2,7, 3,2, 3,9),              4'hF, 4, 0, 1);
    add(0, 1, 1, 0, 6,  3,  pk(6,3, 0,0, 0,0, 0,0),              4'h1, 1, 1, 0);
    add(0, 0, 1, 0, 4,  10, pk(4,10, 6,3, 0,0, 0,0),             4'h3, 2, 1, 0);
    add(0, 0, 0, 1, 1,  1,  pk(4,10, 6,3, 0,0, 0,0),             4'h3, 2, 0, 0);
    add(1, 1, 1, 0, 1,  1,  pk(0,0, 0,0, 0,0, 0,0),              4'h0, 0, 0, 0);
    add(0, 0, 1, 0, 2,  2,  pk(0,0, 0,0, 0,0, 0,0),              4'h0, 0, 0, 0);
    add(0, 1, 1, 1, 5,  2,  pk(5,2, 0,0, 0,0, 0,0),              4'h1, 1, 1, 1);
    add(0, 0, 1, 0, 1,  1,  pk(5,2, 0,0, 0,0, 0,0),              4'h1, 1, 0, 1);
    add(0, 1, 0, 0, 0,  0,  pk(0,0, 0,0, 0,0, 0,0),              4'h0, 0, 0, 0);

    foreach (vecs[k]) begin
      string t;
      t = $sformatf("v%0d", k);
      cycle(t, vecs[k].rst, vecs[k].start, vecs[k].valid, vecs[k].last, vecs[k].d, vecs[k].l);
      check({t, "_list"},  64'(list_out), 64'(vecs[k].e_list));
      check({t, "_occ"},   64'(occ),      64'(vecs[k].e_occ));
      check({t, "_count"}, 64'(count),    64'(vecs[k].e_count));
      check({t, "_hit"},   64'(hit),      64'(vecs[k].e_hit));
      check({t, "_done"},  64'(done),     64'(vecs[k].e_done));
    end

    // Randomized traffic; small distance range forces ties and saturation.
    cycle("r_start", 0, 1, 0, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      bit r, s, v, la;
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 5);
      v  = ($urandom_range(0, 99) < 75);
      la = ($urandom_range(0, 99) < 6);
      cycle($sformatf("r%0d", n), r, s, v, la,
            int'($urandom_range(0, 15)) + ((n % 50 == 0) ? 240 : 0),
            int'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
